spi_rx_pipe_buffer: RTL

Downstream consumer of the SPI slave receiver. Captures each completed 32-bit word on the slave's rdy rising edge and stores it in a FIFO. Drains the FIFO as a 16-bit stream, low half first, to the block-throttled pipe-out endpoint (ep_read/ep_datain/ep_ready). Also exports word and overflow counters to wire-outs.

---
 rtl/spi_link_pkg.sv | 14 +
 rtl/spi_word_fifo.sv | 68 ++++++
 rtl/spi_rx_pipe_buffer.sv | 83 ++++++++
 3 files changed

// File: rtl/spi_link_pkg.sv
// Shared widths, default sizing and helper types for the SPI receive link.
package spi_link_pkg;
  localparam int unsigned SPI_WORD_W      = 32;
  localparam int unsigned PIPE_W          = 16;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_AW          = 4;
  localparam int unsigned DEF_BLOCK_WORDS = 8;
  localparam logic [15:0] OVF_SAT         = 16'hFFFF;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_sel_t;
endpackage

// File: rtl/spi_word_fifo.sv
// Synchronous word FIFO with registered level/empty/full and async-read storage.
module spi_word_fifo
  import spi_link_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned W     = SPI_WORD_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  level,
  output logic         empty,
  output logic         full
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   level_nxt;

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == FULL_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/spi_rx_pipe_buffer.sv
// Captures SPI slave words on rdy rising edges and streams them out as 16-bit halves.
module spi_rx_pipe_buffer
  import spi_link_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [SPI_WORD_W-1:0] rx_word,
  input  logic                  rx_rdy,
  input  logic                  rd_en,
  output logic [PIPE_W-1:0]     dout,
  output logic                  empty,
  output logic                  full,
  output logic                  pipe_ready,
  output logic [AW:0]           level,
  output logic [31:0]           frame_cnt,
  output logic [15:0]           overflow_cnt
);
  localparam logic [AW:0] BLK_LVL = (AW+1)'(BLOCK_WORDS);

  logic                  rdy_d;
  half_sel_t             half_sel;
  logic                  wr_stb;
  logic                  pop;
  logic                  accept;
  logic                  drop;
  logic [SPI_WORD_W-1:0] head;

  assign wr_stb = rx_rdy & ~rdy_d;
  assign pop    = rd_en & ~empty & (half_sel == HALF_HI);
  assign accept = wr_stb & (~full | pop);
  assign drop   = wr_stb & full & ~pop;

  spi_word_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (SPI_WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (wr_stb),
    .pop     (pop),
    .wdata   (rx_word),
    .rdata   (head),
    .level   (level),
    .empty   (empty),
    .full    (full)
  );

  always_comb begin
    dout = '0;
    if (!empty) dout = (half_sel == HALF_HI) ? head[31:16] : head[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_d        <= 1'b0;
      half_sel     <= HALF_LO;
      frame_cnt    <= '0;
      overflow_cnt <= '0;
      pipe_ready   <= 1'b0;
    end else begin
      rdy_d <= rx_rdy;
      if (clear) begin
        half_sel     <= HALF_LO;
        frame_cnt    <= '0;
        overflow_cnt <= '0;
        pipe_ready   <= 1'b0;
      end else begin
        if (rd_en && !empty) half_sel <= (half_sel == HALF_HI) ? HALF_LO : HALF_HI;
        if (accept) frame_cnt <= frame_cnt + 32'd1;
        if (drop && overflow_cnt != OVF_SAT) overflow_cnt <= overflow_cnt + 16'd1;
        // Hold ready through the high half so a block never ends mid-word.
        pipe_ready <= (level >= BLK_LVL) | (pipe_ready & (half_sel == HALF_HI));
      end
    end
  end
endmodule
